// File: rtl/dcim_pe_sequencer.sv
// dcim_pe_sequencer: host-side weight loader, activation issuer and result streamer for one DCIM PE.
module dcim_pe_sequencer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int PE_LAT    = 2,
    parameter int ADDR_SKEW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic [7:0]  in_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_last,
    output logic        busy,
    output logic        err,
    output logic        pe_rst_n,
    output logic        pe_ce,
    output logic        pe_init_en,
    output logic [7:0]  pe_data_in,
    input  logic [15:0] pe_data_out,
    input  logic        pe_init_done
);
    typedef enum logic [2:0] {IDLE, PE_RST, W_LOAD, W_WAIT, READY, W_FILL, A_ISSUE} state_t;
    localparam logic [AW:0]   LAST     = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] SKEW     = AW'(ADDR_SKEW);

    state_t state, state_nx;
    logic [7:0]    wbuf [DEPTH];
    logic [7:0]    abuf [DEPTH];
    logic [16:0]   fifo [DEPTH];
    logic [AW-1:0] tag_i [PE_LAT];
    logic [PE_LAT-1:0] tag_v;
    logic [AW:0]   wcnt, acnt, fcnt;
    logic [AW-1:0] mptr, idx, wr, rd;
    logic pe_on, started, act, acc, inflight, push, pop;

    assign acc      = in_valid && in_ready;
    assign idx      = mptr - SKEW;
    assign act      = state == A_ISSUE && (started || mptr == SKEW);
    assign inflight = |tag_v;
    assign push     = tag_v[PE_LAT-1];
    assign pop      = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A launch needs the whole FIFO free: the PE cannot be stalled once issue starts.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, W_FILL: if (acc && !in_op && wcnt == LAST) state_nx = PE_RST;
            PE_RST:       state_nx = W_LOAD;
            W_LOAD:       if (wcnt == LAST) state_nx = W_WAIT;
            W_WAIT:       if (pe_init_done) state_nx = READY;
            READY:        if (acc && !in_op) state_nx = W_FILL;
                          else if (acnt == FULL && fcnt == '0) state_nx = A_ISSUE;
            A_ISSUE:      if (act && idx == IDX_LAST) state_nx = READY;
            default:      state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = rst_n && (state == IDLE || (state == W_FILL && !in_op) ||
                     (state == READY && (in_op ? acnt != FULL : acnt == '0 && !inflight)));
        busy       = !(state == IDLE || state == READY);
        pe_rst_n   = pe_on && state != PE_RST;
        pe_ce      = pe_on || state == PE_RST;
        pe_init_en = state == W_LOAD && wcnt == '0;
        pe_data_in = state == W_LOAD ? wbuf[wcnt[AW-1:0]] : act ? abuf[idx] : '0;
        res_valid  = fcnt != '0;
        {res_last, res_data} = res_valid ? fifo[rd] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt    <= '0;
            acnt    <= '0;
            mptr    <= '0;
            pe_on   <= 1'b0;
            started <= 1'b0;
            err     <= 1'b0;
            tag_v   <= '0;
            wr      <= '0;
            rd      <= '0;
            fcnt    <= '0;
        end else begin
            if (acc && !in_op) wcnt <= state == READY ? (AW+1)'(1) : wcnt + 1'b1;
            else if (state == PE_RST) wcnt <= '0;
            else if (state == W_LOAD) wcnt <= wcnt + 1'b1;
            if (acc && in_op && state == READY) acnt <= acnt + 1'b1;
            else if (act && idx == IDX_LAST) acnt <= '0;
            err     <= err || (acc && in_op && state == IDLE);
            pe_on   <= pe_on || state == PE_RST;
            mptr    <= state == W_WAIT && pe_init_done ? '0 : mptr + 1'b1;
            started <= act && idx != IDX_LAST;
            tag_v   <= PE_LAT'({tag_v, act});
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            fcnt    <= fcnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (acc && !in_op) wbuf[state == READY ? AW'(0) : wcnt[AW-1:0]] <= in_data;
        if (acc && in_op && state == READY) abuf[acnt[AW-1:0]] <= in_data;
        if (push) fifo[wr] <= {tag_i[PE_LAT-1] == IDX_LAST, pe_data_out};
        tag_i[0] <= idx;
        for (int i = 1; i < PE_LAT; i++) tag_i[i] <= tag_i[i-1];
    end
endmodule

// File: tb/tb_dcim_pe_sequencer.sv
// tb_dcim_pe_sequencer: directed bench with a behavioural PE (init burst, free-running pointer, 2-cycle multiply).
module tb_dcim_pe_sequencer;
    logic clk = 0, rst_n = 0, in_valid = 0, in_op = 0, res_ready = 1, pe_init_done = 0;
    logic in_ready, res_valid, res_last, busy, err, pe_rst_n, pe_ce, pe_init_en;
    logic [7:0]  in_data = 0, pe_data_in;
    logic [15:0] res_data, pe_data_out = 0;
    int checks = 0, errors = 0;
    logic [16:0] q[$];

    always #5 clk = ~clk;

    dcim_pe_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .err(err), .pe_rst_n(pe_rst_n), .pe_ce(pe_ce),
        .pe_init_en(pe_init_en), .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
        .pe_init_done(pe_init_done)
    );

    // PE: pointer reads 0 the cycle after init_done rises; data at pointer p uses weight p-1
    logic [7:0]  w [16];
    logic [3:0]  ptr = 0, lc = 0;
    logic        loading = 0;
    logic [15:0] p1 = 0;
    always @(posedge clk) begin
        if (!pe_rst_n) begin
            loading <= 0; pe_init_done <= 0; lc <= 0;
        end else if (pe_ce) begin
            if (pe_init_en) begin w[0] <= pe_data_in; lc <= 1; loading <= 1; end
            else if (loading) begin
                w[lc] <= pe_data_in; lc <= lc + 1;
                if (lc == 15) begin loading <= 0; pe_init_done <= 1; ptr <= 15; end
            end else if (pe_init_done) ptr <= ptr + 1;
        end
        p1 <= 16'(w[ptr - 4'd1]) * 16'(pe_data_in);
        pe_data_out <= p1;
    end

    always @(negedge clk) if (rst_n && res_valid && res_ready) q.push_back({res_last, res_data});

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic send(input logic op, input logic [7:0] d);
        int n = 0;
        in_valid = 1; in_op = op; in_data = d;
        #1;
        while (!in_ready && n < 2000) begin @(posedge clk); #2; n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL send_timeout op=%0d data=%0d in_ready=%0b required 1", op, d, in_ready); end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 600 && q.size() < n; i++) tick();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 0; tick(); tick();
        checks++;
        if ({in_ready, res_valid, res_last, busy, err, pe_rst_n, pe_ce, pe_init_en} !== 8'b0) begin
            errors++; $display("FAIL reset_flags got=%b required 00000000",
                {in_ready, res_valid, res_last, busy, err, pe_rst_n, pe_ce, pe_init_en});
        end
        checks++;
        if (pe_data_in !== 8'd0 || res_data !== 16'd0) begin
            errors++; $display("FAIL reset_data pe_data_in=%0d res_data=%0d required 0 0", pe_data_in, res_data);
        end
        rst_n = 1; tick();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL idle_after_reset in_ready,busy=%b required 10", {in_ready, busy}); end
    endtask

    task automatic test_err_before_weights();
        send(1, 8'h05);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_set err=%b required 1", err); end
        checks++;
        if ({busy, in_ready, pe_rst_n, pe_ce} !== 4'b0100) begin
            errors++; $display("FAIL err_stays_idle busy,in_ready,pe_rst_n,pe_ce=%b required 0100", {busy, in_ready, pe_rst_n, pe_ce});
        end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL err_no_result res_valid=%b required 0", res_valid); end
    endtask

    task automatic test_load_burst();
        int cyc;
        for (int k = 1; k <= 16; k++) send(0, 8'(k));
        checks++;
        if ({pe_rst_n, busy, in_ready} !== 3'b010) begin
            errors++; $display("FAIL pe_rst_pulse pe_rst_n,busy,in_ready=%b required 010", {pe_rst_n, busy, in_ready});
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if ({pe_init_en, pe_data_in, pe_rst_n} !== {logic'(k == 0), 8'(k + 1), 1'b1}) begin
                errors++; $display("FAIL load_cycle_%0d init_en=%b data=%0d rst_n=%b required %b %0d 1",
                    k, pe_init_en, pe_data_in, pe_rst_n, logic'(k == 0), k + 1);
            end
        end
        cyc = 17;
        while (busy && cyc < 60) begin tick(); cyc++; end
        checks++;
        if (busy || cyc > 19) begin errors++; $display("FAIL ready_latency cycles=%0d busy=%b required <=19 0", cyc, busy); end
    endtask

    task automatic test_basic_vector();
        q.delete(); res_ready = 1;
        for (int k = 0; k < 16; k++) send(1, 8'd1);
        wait_q(16);
        checks++;
        if (q.size() != 16) begin errors++; $display("FAIL basic_count got=%0d required 16", q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q[i] !== {logic'(i == 15), 16'(i + 1)}) begin
                errors++; $display("FAIL basic_res_%0d got=%h required %h", i, q[i], {logic'(i == 15), 16'(i + 1)});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        q.delete(); res_ready = 0;
        for (int k = 0; k < 16; k++) send(1, 8'd2);
        for (int k = 0; k < 16; k++) send(1, 8'd3);
        repeat (10) tick();
        in_op = 1; #1;
        checks++;
        if ({busy, res_valid, in_ready} !== 3'b010) begin
            errors++; $display("FAIL bp_hold busy,res_valid,in_ready=%b required 010", {busy, res_valid, in_ready});
        end
        checks++;
        if ({res_last, res_data} !== {1'b0, 16'd2} || q.size() != 0) begin
            errors++; $display("FAIL bp_head last=%b data=%0d popped=%0d required 0 2 0", res_last, res_data, q.size());
        end
        res_ready = 1;
        wait_q(32);
        checks++;
        if (q.size() != 32) begin errors++; $display("FAIL bp_count got=%0d required 32", q.size()); end
        for (int i = 0; i < 32; i++) begin
            exp = i < 16 ? {logic'(i == 15), 16'(2 * (i + 1))} : {logic'(i == 31), 16'(3 * (i - 15))};
            checks++;
            if (q[i] !== exp) begin errors++; $display("FAIL bp_res_%0d got=%h required %h", i, q[i], exp); end
        end
    endtask

    task automatic test_reload();
        int n = 0;
        q.delete(); res_ready = 1;
        send(0, 8'd16);
        in_op = 1; #1;
        checks++;
        if ({busy, pe_rst_n, in_ready} !== 3'b110) begin
            errors++; $display("FAIL reload_fill busy,pe_rst_n,in_ready=%b required 110", {busy, pe_rst_n, in_ready});
        end
        for (int k = 2; k <= 16; k++) send(0, 8'(17 - k));
        checks++;
        if (pe_rst_n !== 1'b0) begin errors++; $display("FAIL reload_rst_low pe_rst_n=%b required 0", pe_rst_n); end
        tick();
        checks++;
        if ({pe_rst_n, pe_init_en, pe_data_in} !== {1'b1, 1'b1, 8'd16}) begin
            errors++; $display("FAIL reload_rst_high rst_n=%b init_en=%b data=%0d required 1 1 16", pe_rst_n, pe_init_en, pe_data_in);
        end
        while (busy && n < 60) begin tick(); n++; end
        for (int k = 0; k < 16; k++) send(1, 8'd1);
        wait_q(16);
        checks++;
        if (q.size() != 16) begin errors++; $display("FAIL reload_count got=%0d required 16", q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q[i] !== {logic'(i == 15), 16'(16 - i)}) begin
                errors++; $display("FAIL reload_res_%0d got=%h required %h", i, q[i], {logic'(i == 15), 16'(16 - i)});
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        q.delete();
        for (int k = 0; k < 16; k++) send(1, 8'd1);
        while (pe_data_in == 8'd0 && n < 100) begin tick(); n++; end
        repeat (7) tick();
        checks++;
        if ({busy, pe_data_in} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL issue_cycle7 busy=%b data=%0d required 1 1", busy, pe_data_in);
        end
        rst_n = 0; tick();
        checks++;
        if ({in_ready, res_valid, res_last, busy, err, pe_rst_n, pe_ce, pe_init_en} !== 8'b0) begin
            errors++; $display("FAIL midrst_flags got=%b required 00000000",
                {in_ready, res_valid, res_last, busy, err, pe_rst_n, pe_ce, pe_init_en});
        end
        checks++;
        if (pe_data_in !== 8'd0 || res_data !== 16'd0) begin
            errors++; $display("FAIL midrst_data pe_data_in=%0d res_data=%0d required 0 0", pe_data_in, res_data);
        end
        rst_n = 1; in_op = 0; tick();
        checks++;
        if ({in_ready, busy, err} !== 3'b100) begin
            errors++; $display("FAIL midrst_idle in_ready,busy,err=%b required 100", {in_ready, busy, err});
        end
        repeat (5) tick();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_stray res_valid=%b required 0", res_valid); end
    endtask

    initial begin
        test_reset();
        test_err_before_weights();
        test_load_burst();
        test_basic_vector();
        test_back_to_back();
        test_reload();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
